// File: rtl/mips_pkg.sv
// Shared encodings for the execute-stage ALU and the iterative multiply/divide engine.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply / restoring divide on operand magnitudes,
// sign fix-up applied on the final step so HI/LO are written once, at the CALC->FIN edge.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [1:0]       i_md_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wr_en,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt
);
    localparam int unsigned CW = $clog2(WIDTH);

    md_state_t           r_state, w_state_nxt;
    logic [CW-1:0]       r_count;
    logic [2*WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]    r_opb;
    logic                r_is_div, r_neg_q, r_neg_r, r_dz;

    logic                w_signed, w_is_div, w_a_neg, w_b_neg, w_last;
    logic [WIDTH-1:0]    w_a_mag, w_b_mag;
    logic [WIDTH:0]      w_mul_upper, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0]  w_mul_acc, w_div_acc, w_acc_step, w_prod;
    logic [WIDTH-1:0]    w_quo, w_rem;

    assign w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
    assign w_is_div = (i_md_op == MD_DIV)  || (i_md_op == MD_DIVU);
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;
    assign w_last   = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = CALC;
            CALC:    if (w_last)  w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state != IDLE);
        o_done  = (r_state == FIN);
        o_wr_en = (r_state == CALC) && w_last;
    end

    // Both ops start with the multiplier/dividend magnitude in the low half of the accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_count  <= '0;
            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
            r_opb    <= w_b_mag;
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (i_b == '0);
        end else if (r_state == CALC) begin
            r_count  <= r_count + 1'b1;
            r_acc    <= w_acc_step;
        end
    end

    always_comb begin
        w_mul_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_acc   = {w_mul_upper, r_acc[WIDTH-1:1]};
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_acc   = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
        w_acc_step  = r_is_div ? w_div_acc : w_mul_acc;
    end

    // Divide by zero leaves the dividend magnitude as remainder, so only LO needs overriding.
    always_comb begin
        w_prod = r_neg_q ? -w_acc_step : w_acc_step;
        w_quo  = w_acc_step[WIDTH-1:0];
        w_rem  = w_acc_step[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            o_lo_nxt = r_dz ? '1 : (r_neg_q ? -w_quo : w_quo);
            o_hi_nxt = r_neg_r ? -w_rem : w_rem;
        end else begin
            o_lo_nxt = w_prod[WIDTH-1:0];
            o_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage datapath: combinational ALU plus HI/LO registers fed by the iterative mul/div engine.
module alu_muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] w_sum, w_diff, w_hi_nxt, w_lo_nxt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             w_wr_en, w_slt;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_slt  = $signed(a) < $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = w_sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = w_diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_slt};
            default: ;
        endcase
    end

    assign zero = (result == '0);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (md_start),
        .i_md_op  (md_op),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (md_busy),
        .o_done   (md_done),
        .o_wr_en  (w_wr_en),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_wr_en) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
